// File: rtl/ebuf_pkg.sv
// ebuf_pkg: elastic-buffer state encoding and gray-code helpers shared by both pointer controllers.
package ebuf_pkg;
   typedef enum logic [1:0] {NORMAL, REMOVE, ADD} ebuf_state_e;
   // Helpers work at a fixed maximum width; callers zero-extend and truncate to their pointer width.
   localparam int GW = 16;
   function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b[GW-1] = g[GW-1];
      for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: multi-flop synchroniser for a gray-coded pointer crossing into this clock domain.
module gray_ptr_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             rx_clk,
   input  logic             rx_rst,
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_gray
);
   logic [WIDTH-1:0] r_sync [STAGES];
   always_ff @(posedge rx_clk) begin
      if (rx_rst) r_sync <= '{default: '0};
      else begin
         r_sync[0] <= i_gray;
         for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end
   assign o_gray = r_sync[STAGES-1];
endmodule

// File: rtl/ebuf_wptr_ctrl.sv
// ebuf_wptr_ctrl: RX elastic-buffer write pointer, fill level and SKP add/remove hysteresis control.
module ebuf_wptr_ctrl
   import ebuf_pkg::*;
#(
   parameter  int ADDR_WIDTH  = 3,
   parameter  int HI_THRESH   = 6,
   parameter  int LO_THRESH   = 2,
   parameter  int SYNC_STAGES = 2,
   localparam int PTR_WIDTH   = ADDR_WIDTH + 1
) (
   input  logic                  rx_clk,
   input  logic                  rx_rst,
   input  logic                  LTSSM_rst,
   input  logic                  write_en,
   input  logic                  is_skp,
   input  logic [PTR_WIDTH-1:0]  r_gray_rptr,
   output logic                  wr_commit,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [PTR_WIDTH-1:0]  wptr,
   output logic [PTR_WIDTH-1:0]  gray_wptr,
   output logic [PTR_WIDTH-1:0]  fill_level,
   output logic                  full,
   output logic                  skp_rmv_rqst,
   output logic                  skp_add_rqst,
   output logic                  skp_dropped,
   output logic                  overflow
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [PTR_WIDTH-1:0] W_DEPTH = PTR_WIDTH'(DEPTH);
   localparam logic [PTR_WIDTH-1:0] W_HI    = PTR_WIDTH'(HI_THRESH);
   localparam logic [PTR_WIDTH-1:0] W_LO    = PTR_WIDTH'(LO_THRESH);
   localparam logic [PTR_WIDTH-1:0] W_MID   = PTR_WIDTH'((HI_THRESH + LO_THRESH) / 2);

   if (!(LO_THRESH > 0 && LO_THRESH < HI_THRESH && HI_THRESH < DEPTH) || SYNC_STAGES < 2) begin : g_bad_params
      $error("ebuf_wptr_ctrl: illegal threshold or sync-stage parameters");
   end

   logic                 w_rst, w_drop, w_full;
   logic [PTR_WIDTH-1:0] w_gray_rptr_sync, w_rptr_bin, w_fill, w_wptr_next;
   logic [PTR_WIDTH-1:0] r_wptr, r_gray_wptr;
   logic                 r_skp_run, r_skp_dropped, r_overflow;
   ebuf_state_e          r_state;

   assign w_rst = rx_rst | LTSSM_rst;

   gray_ptr_sync #(.WIDTH(PTR_WIDTH), .STAGES(SYNC_STAGES)) u_rptr_sync (
      .rx_clk (rx_clk),
      .rx_rst (w_rst),
      .i_gray (r_gray_rptr),
      .o_gray (w_gray_rptr_sync)
   );

   assign w_rptr_bin  = PTR_WIDTH'(gray2bin(GW'(w_gray_rptr_sync)));
   assign w_fill      = r_wptr - w_rptr_bin;
   assign w_full      = w_fill == W_DEPTH;
   // At most one SKP is dropped per run of consecutive SKPs.
   assign w_drop      = write_en & is_skp & (r_state == REMOVE) & ~r_skp_run;
   assign wr_commit   = write_en & ~w_full & ~w_drop & ~w_rst;
   assign w_wptr_next = r_wptr + PTR_WIDTH'(wr_commit);

   always_ff @(posedge rx_clk) begin
      if (w_rst) begin
         r_wptr        <= '0;
         r_gray_wptr   <= '0;
         r_state       <= NORMAL;
         r_skp_run     <= 1'b0;
         r_skp_dropped <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_wptr        <= w_wptr_next;
         r_gray_wptr   <= PTR_WIDTH'(bin2gray(GW'(w_wptr_next)));
         r_skp_dropped <= w_drop;
         r_overflow    <= r_overflow | (write_en & w_full & ~w_drop);
         if (write_en) r_skp_run <= is_skp;
         unique case (r_state)
            NORMAL:  r_state <= (w_fill > W_HI) ? REMOVE : (w_fill < W_LO) ? ADD : NORMAL;
            REMOVE:  r_state <= (w_fill <= W_MID) ? NORMAL : REMOVE;
            ADD:     r_state <= (w_fill >= W_MID) ? NORMAL : ADD;
            default: r_state <= NORMAL;
         endcase
      end
   end

   assign waddr        = r_wptr[ADDR_WIDTH-1:0];
   assign wptr         = r_wptr;
   assign gray_wptr    = r_gray_wptr;
   assign fill_level   = w_fill;
   assign full         = w_full;
   assign skp_rmv_rqst = r_state == REMOVE;
   assign skp_add_rqst = r_state == ADD;
   assign skp_dropped  = r_skp_dropped;
   assign overflow     = r_overflow;
endmodule

// File: tb/tb_ebuf_wptr_ctrl.sv
// tb_ebuf_wptr_ctrl: directed self-checking bench for the elastic-buffer write-side controller.
module tb_ebuf_wptr_ctrl;
   logic       rx_clk = 1'b0, rx_rst, LTSSM_rst, write_en, is_skp;
   logic [3:0] r_gray_rptr;
   logic       wr_commit, full, skp_rmv_rqst, skp_add_rqst, skp_dropped, overflow;
   logic [2:0] waddr;
   logic [3:0] wptr, gray_wptr, fill_level, prev_gray;
   int         checks = 0, failures = 0, exp_w;

   ebuf_wptr_ctrl dut (
      .rx_clk(rx_clk), .rx_rst(rx_rst), .LTSSM_rst(LTSSM_rst), .write_en(write_en), .is_skp(is_skp),
      .r_gray_rptr(r_gray_rptr), .wr_commit(wr_commit), .waddr(waddr), .wptr(wptr),
      .gray_wptr(gray_wptr), .fill_level(fill_level), .full(full), .skp_rmv_rqst(skp_rmv_rqst),
      .skp_add_rqst(skp_add_rqst), .skp_dropped(skp_dropped), .overflow(overflow)
   );

   always #5 rx_clk = ~rx_clk;

   function automatic logic [3:0] g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic tick();
      @(posedge rx_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rx_rst = 1'b1;
      tick();
      rx_rst = 1'b0;
   endtask

   initial begin
      rx_rst = 1'b1; LTSSM_rst = 1'b0; write_en = 1'b0; is_skp = 1'b0; r_gray_rptr = '0;
      tick(); tick();
      chk("rst_wptr", wptr, 0);
      chk("rst_gray", gray_wptr, 0);
      chk("rst_fill", fill_level, 0);
      chk("rst_full", full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_drop", skp_dropped, 0);
      chk("rst_rmv", skp_rmv_rqst, 0);
      chk("rst_add", skp_add_rqst, 0);
      rx_rst = 1'b0;
      // three writes, then rx_rst with write_en still high
      write_en = 1'b1;
      tick(); tick(); tick();
      chk("pre_rst_wptr", wptr, 3);
      chk("pre_rst_waddr", waddr, 3);
      chk("pre_rst_gray", gray_wptr, g(4'd3));
      rx_rst = 1'b1;
      #1 chk("rst_no_commit", wr_commit, 0);
      tick();
      chk("rst2_wptr", wptr, 0);
      chk("rst2_gray", gray_wptr, 0);
      chk("rst2_fill", fill_level, 0);
      rx_rst = 1'b0;
      // fill to full, then overflow
      for (int i = 0; i < 8; i++) tick();
      chk("fill8_level", fill_level, 8);
      chk("fill8_full", full, 1);
      chk("fill8_ovf", overflow, 0);
      chk("fill8_rmv", skp_rmv_rqst, 1);
      #1 chk("full_no_commit", wr_commit, 0);
      tick();
      chk("ovf_set", overflow, 1);
      chk("ovf_wptr_held", wptr, 8);
      write_en = 1'b0;
      tick();
      chk("ovf_sticky", overflow, 1);
      do_reset();
      chk("ovf_cleared", overflow, 0);
      // wrap: read side tracks the write pointer
      exp_w = 0;
      for (int i = 0; i < 40; i++) begin
         write_en = 1'b1;
         prev_gray = gray_wptr;
         tick();
         exp_w = (exp_w + 1) % 16;
         chk("wrap_gray_onebit", $countones(gray_wptr ^ prev_gray), 1);
         chk("wrap_gray_val", gray_wptr, g(4'(exp_w)));
         r_gray_rptr = g(4'(exp_w));
      end
      write_en = 1'b0;
      chk("wrap_wptr", wptr, 8);
      chk("wrap_gray", gray_wptr, 4'hC);
      tick(); tick();
      chk("wrap_fill0", fill_level, 0);
      chk("wrap_no_ovf", overflow, 0);
      // remove: fill 7 then SKP,SKP,SKP,data
      r_gray_rptr = '0;
      do_reset();
      write_en = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      chk("rm_fill7", fill_level, 7);
      chk("rm_not_yet", skp_rmv_rqst, 0);
      write_en = 1'b0;
      tick();
      chk("rm_enter", skp_rmv_rqst, 1);
      write_en = 1'b1; is_skp = 1'b1; r_gray_rptr = g(4'd2);
      #1 chk("rm_skp1_commit", wr_commit, 0);
      tick();
      chk("rm_skp1_pulse", skp_dropped, 1);
      chk("rm_skp1_wptr", wptr, 7);
      #1 chk("rm_skp2_commit", wr_commit, 1);
      tick();
      chk("rm_skp2_pulse", skp_dropped, 0);
      chk("rm_skp2_wptr", wptr, 8);
      chk("rm_skp2_fill", fill_level, 6);
      tick();
      chk("rm_skp3_pulse", skp_dropped, 0);
      chk("rm_skp3_wptr", wptr, 9);
      is_skp = 1'b0;
      tick();
      chk("rm_data_wptr", wptr, 10);
      chk("rm_data_pulse", skp_dropped, 0);
      chk("rm_data_fill", fill_level, 8);
      chk("rm_no_ovf", overflow, 0);
      chk("rm_still", skp_rmv_rqst, 1);
      write_en = 1'b0; r_gray_rptr = g(4'd6);
      tick(); tick();
      chk("rm_fill4", fill_level, 4);
      chk("rm_hold", skp_rmv_rqst, 1);
      tick();
      chk("rm_exit", skp_rmv_rqst, 0);
      // add: low fill enters ADD, exits at MID
      r_gray_rptr = '0;
      do_reset();
      write_en = 1'b1;
      tick();
      chk("add_fill1", fill_level, 1);
      chk("add_enter", skp_add_rqst, 1);
      tick(); tick();
      chk("add_fill3", fill_level, 3);
      chk("add_hold3", skp_add_rqst, 1);
      tick();
      chk("add_fill4", fill_level, 4);
      write_en = 1'b0;
      tick();
      chk("add_exit", skp_add_rqst, 0);
      // LTSSM soft clear with a write in the same cycle
      write_en = 1'b1; LTSSM_rst = 1'b1;
      #1 chk("ltssm_no_commit", wr_commit, 0);
      tick();
      LTSSM_rst = 1'b0; write_en = 1'b0;
      chk("ltssm_wptr", wptr, 0);
      chk("ltssm_gray", gray_wptr, 0);
      chk("ltssm_fill", fill_level, 0);
      write_en = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      chk("ltssm_pre_ovf", overflow, 1);
      LTSSM_rst = 1'b1;
      tick();
      LTSSM_rst = 1'b0; write_en = 1'b0;
      chk("ltssm_ovf", overflow, 0);
      chk("ltssm_full", full, 0);
      chk("ltssm_rmv", skp_rmv_rqst, 0);
      chk("ltssm_add", skp_add_rqst, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
